// File: rtl/lcr580_bus_pkg.sv
// Shared LCR580 bus definitions: bus widths, arbiter parameter limits and
// the arbiter state encoding.
package lcr580_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam int BURST_MIN   = 1;
    localparam int BURST_MAX   = 16;
    localparam int CPU_MIN_MAX = 15;

    typedef enum logic {
        S_CPU = 1'b0,
        S_VID = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lcr580_mem_arbiter.sv
// Single-port RAM arbiter: the CPU owns the bus by default. A video grant
// stalls the CPU for one fixed-length burst, then a guard window protects the CPU.
module lcr580_mem_arbiter
    import lcr580_bus_pkg::*;
#(
    parameter int BURST   = 4,
    parameter int CPU_MIN = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_in,
    output logic              cpu_ce,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_address,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_out,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_in
);

    localparam logic [3:0] BEAT_LAST = 4'(BURST - 1);
    // The exit edge itself is the first CPU cycle, so the guard holds one less
    // than CPU_MIN; the next grant decision then lands on edge k+BURST+CPU_MIN.
    localparam logic [3:0] GUARD_LOAD = (CPU_MIN > 0) ? 4'(CPU_MIN - 1) : 4'd0;
    localparam logic       REGRANT_AT_EXIT = (CPU_MIN == 0);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              grant;
    logic [ADDR_W-1:0] ptr;
    logic [3:0]        beat;
    logic [3:0]        guard;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_CPU;
            ptr    <= '0;
            beat   <= '0;
            guard  <= '0;
            cpu_ce <= 1'b1;
        end else begin
            state <= state_next;
            if (grant) begin
                ptr    <= vid_address;
                beat   <= BEAT_LAST;
                cpu_ce <= 1'b0;
            end else if (state == S_VID) begin
                ptr <= ptr + 1'b1;
                if (beat != 4'd0) begin
                    beat <= beat - 1'b1;
                end else begin
                    cpu_ce <= 1'b1;
                    guard  <= GUARD_LOAD;
                end
            end else if (guard != 4'd0) begin
                guard <= guard - 1'b1;
            end
        end
    end

    // With no guard window, a held request chains straight into the next burst.
    always_comb begin
        grant      = 1'b0;
        state_next = state;
        case (state)
            S_CPU: begin
                if (guard == 4'd0 && vid_req) begin
                    grant      = 1'b1;
                    state_next = S_VID;
                end
            end
            S_VID: begin
                if (beat == 4'd0) begin
                    if (REGRANT_AT_EXIT && vid_req) begin
                        grant = 1'b1;
                    end else begin
                        state_next = S_CPU;
                    end
                end
            end
            default: state_next = S_CPU;
        endcase
    end

    always_comb begin
        ram_address = cpu_address;
        ram_we      = cpu_we & cpu_ce;
        vid_valid   = 1'b0;
        vid_done    = 1'b0;
        if (state == S_VID) begin
            ram_address = ptr;
            ram_we      = 1'b0;
            vid_valid   = 1'b1;
            vid_done    = (beat == 4'd0);
        end
    end

    assign cpu_in   = ram_in;
    assign vid_data = ram_in;
    assign ram_out  = cpu_out;

endmodule

// File: tb/tb_lcr580_mem_arbiter.sv
// Bench for lcr580_mem_arbiter: a RAM model, a cycle-number reference model of
// grants and bursts, directed scenarios followed by random traffic.
module tb_lcr580_mem_arbiter;

    localparam int BURST   = 4;
    localparam int CPU_MIN = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_out = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_in;
    logic        cpu_ce;
    logic        vid_req = 1'b0;
    logic [15:0] vid_address = '0;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        vid_done;
    logic [15:0] ram_address;
    logic [7:0]  ram_out;
    logic        ram_we;
    logic [7:0]  ram_in;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int checks = 0;
    int errors = 0;

    // Reference model in terms of cycle numbers: cycle c follows edge c.
    int          cyc = 0;
    int          grant_cyc = -1000;
    int          next_ok = 0;
    logic [15:0] grant_addr = '0;
    bit          known = 1'b0;

    always #5 clock = ~clock;

    assign ram_in = mem[ram_address];
    always @(posedge clock) begin
        if (ram_we === 1'b1) mem[ram_address] = ram_out;
    end

    lcr580_mem_arbiter #(.BURST(BURST), .CPU_MIN(CPU_MIN)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_in      (cpu_in),
        .cpu_ce      (cpu_ce),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .vid_done    (vid_done),
        .ram_address (ram_address),
        .ram_out     (ram_out),
        .ram_we      (ram_we),
        .ram_in      (ram_in)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic rst_i, input logic req_i, input logic [15:0] va_i,
                        input logic we_i, input logic [15:0] ca_i, input logic [7:0] cd_i,
                        output logic ce_o, output logic vv_o, output logic dn_o,
                        output logic [7:0] vd_o, output logic [15:0] ra_o);
        bit          in_b;
        int          off;
        int          e;
        logic [15:0] eaddr;
        reset       = rst_i;
        vid_req     = req_i;
        vid_address = va_i;
        cpu_we      = we_i;
        cpu_address = ca_i;
        cpu_out     = cd_i;
        in_b  = known && (cyc >= grant_cyc) && (cyc < grant_cyc + BURST);
        off   = cyc - grant_cyc;
        eaddr = in_b ? grant_addr + 16'(off) : ca_i;
        @(negedge clock);
        ce_o = cpu_ce;
        vv_o = vid_valid;
        dn_o = vid_done;
        vd_o = vid_data;
        ra_o = ram_address;
        if (known) begin
            chk("cpu_ce", 16'(cpu_ce), 16'(!in_b));
            chk("vid_valid", 16'(vid_valid), 16'(in_b));
            chk("vid_done", 16'(vid_done), 16'(in_b && off == BURST - 1));
            chk("ram_address", ram_address, eaddr);
            chk("ram_we", 16'(ram_we), 16'(!in_b && we_i));
            chk("cpu_in", 16'(cpu_in), 16'(ref_mem[eaddr]));
            if (in_b) chk("vid_data", 16'(vid_data), 16'(ref_mem[eaddr]));
        end
        @(posedge clock);
        e = cyc + 1;
        if (known && !in_b && we_i) ref_mem[ca_i] = cd_i;
        if (rst_i) begin
            known     = 1'b1;
            grant_cyc = -1000;
            next_ok   = e + 1;
        end else if (known && req_i && e >= next_ok) begin
            grant_cyc  = e;
            grant_addr = va_i;
            next_ok    = e + BURST + CPU_MIN;
        end
        cyc = e;
        #1;
    endtask

    initial begin
        logic        ce, vv, dn;
        logic [7:0]  vd;
        logic [15:0] ra;
        logic [11:0] trace;
        int          diff;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[16'h2000 + i]     = 8'(8'h11 * (i + 1));
            ref_mem[16'h2000 + i] = 8'(8'h11 * (i + 1));
        end
        mem[16'h1234] = 8'h00; ref_mem[16'h1234] = 8'h00;
        mem[16'h4000] = 8'h00; ref_mem[16'h4000] = 8'h00;
        mem[16'h3000] = 8'h00; ref_mem[16'h3000] = 8'h00;

        // Reset, then a plain CPU write.
        step(1, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        step(1, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        step(0, 0, 16'h0, 1, 16'h1234, 8'h5A, ce, vv, dn, vd, ra);
        chk("reset_ce", 16'(ce), 16'd1);
        chk("reset_vv", 16'(vv), 16'd0);
        step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        chk("wr_1234", 16'(mem[16'h1234]), 16'h5A);

        // Burst from 2000 with a CPU write attempted during the stall.
        step(0, 1, 16'h2000, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        for (int b = 0; b < 4; b++) begin
            step(0, b < 3, 16'h2000, 1, 16'h4000, 8'h77, ce, vv, dn, vd, ra);
            chk("burst_data", 16'(vd), 16'(8'h11 * (b + 1)));
            chk("burst_done", 16'(dn), 16'(b == 3));
            chk("burst_ce", 16'(ce), 16'd0);
        end
        step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        chk("ce_after_burst", 16'(ce), 16'd1);
        chk("stall_wr_blocked", 16'(mem[16'h4000]), 16'h00);
        repeat (2) step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);

        // Address wrap at the top of memory.
        step(0, 1, 16'hFFFE, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        for (int b = 0; b < 4; b++) begin
            step(0, b < 3, 16'hFFFE, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
            chk("wrap_addr", ra, 16'(16'hFFFE + b));
        end
        repeat (3) step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);

        // Continuously held request with CPU writes every cycle.
        step(0, 1, 16'h6000, 1, 16'h5000, 8'hA0, ce, vv, dn, vd, ra);
        trace = '0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 16'h6000, 1, 16'(16'h5100 + i), 8'(i), ce, vv, dn, vd, ra);
            trace = {trace[10:0], ce};
        end
        chk("held_ce_trace", 16'(trace), 16'(12'b000011000011));
        repeat (7) step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);

        // CPU write on the grant-decision cycle commits before the burst.
        step(0, 1, 16'h7000, 1, 16'h3000, 8'h9C, ce, vv, dn, vd, ra);
        chk("wr_3000", 16'(mem[16'h3000]), 16'h9C);
        repeat (4) step(0, 0, 16'h0, 1, 16'h3001, 8'h55, ce, vv, dn, vd, ra);
        repeat (3) step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);

        // Reset in the second burst cycle, then a fresh burst.
        step(0, 1, 16'h8000, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        step(0, 1, 16'h8000, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        step(1, 1, 16'h8000, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        chk("rst_mid_ce", 16'(ce), 16'd1);
        chk("rst_mid_vv", 16'(vv), 16'd0);
        chk("rst_mid_done", 16'(dn), 16'd0);
        step(0, 1, 16'h8100, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
        for (int b = 0; b < 4; b++) begin
            step(0, b < 3, 16'h8100, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);
            chk("fresh_addr", ra, 16'(16'h8100 + b));
        end
        chk("fresh_done", 16'(dn), 16'd1);
        repeat (3) step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic        r_rst, r_req, r_we;
            logic [15:0] r_va, r_ca;
            logic [7:0]  r_cd;
            r_rst = ($urandom_range(0, 63) == 0);
            r_req = ($urandom_range(0, 2) != 0);
            r_va  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                : 16'(16'h2000 + $urandom_range(0, 63));
            r_we  = 1'($urandom_range(0, 1));
            r_ca  = 16'(16'h2000 + $urandom_range(0, 63));
            r_cd  = 8'($urandom);
            step(r_rst, r_req, r_va, r_we, r_ca, r_cd, ce, vv, dn, vd, ra);
        end
        step(0, 0, 16'h0, 0, 16'h0, 8'h0, ce, vv, dn, vd, ra);

        diff = 0;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== ref_mem[i]) diff++;
        end
        chk("ram_final", 16'(diff), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
